tlc_phase_timer: RTL and testbench

//   Upstream timing stage for the four-way traffic light controller. It decides

---
 rtl/tlc_phase_timer.sv | 98 +++++++++
 tb/tb_tlc_phase_timer.sv | 112 +++++++++++
 2 files changed

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: green/extension/clearance timing that issues the phase-step advance pulse
module tlc_phase_timer #(
    parameter int PRESCALE  = 1000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int GAP       = 3,
    parameter int CLEAR     = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       phase_in,
    input  logic [3:0]       veh_det,
    input  logic             hold,
    output logic             advance,
    output logic             clearing,
    output logic [CNT_W-1:0] phase_time,
    output logic             err
);
    localparam int PW = $clog2(PRESCALE);
    typedef enum logic [1:0] {S_MIN, S_EXT, S_CLR} state_t;
    state_t           state_q;
    logic [PW-1:0]    presc_q;
    logic [CNT_W-1:0] pt_q, pt_d, gap_q, clr_q;
    logic [2:0]       phase_q;
    logic [3:0]       mask;
    logic             advance_q, clearing_q, err_q, tick, demand;
    assign tick = !hold && presc_q == PW'(PRESCALE - 1);
    assign mask = phase_in == 3'd0 ? 4'b0101 :
                  phase_in == 3'd1 ? 4'b1010 :
                  phase_in == 3'd2 ? 4'b0001 :
                  phase_in == 3'd3 ? 4'b0010 :
                  phase_in == 3'd4 ? 4'b0100 :
                  phase_in == 3'd5 ? 4'b1000 : 4'b0000;
    assign demand = |(veh_det & mask);
    assign pt_d = &pt_q ? pt_q : pt_q + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_MIN;
            presc_q    <= '0;
            pt_q       <= '0;
            gap_q      <= CNT_W'(GAP);
            clr_q      <= '0;
            phase_q    <= phase_in;
            advance_q  <= 1'b0;
            clearing_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            phase_q   <= phase_in;
            advance_q <= 1'b0;
            if (phase_in > 3'd5) err_q <= 1'b1;
            if (!hold) presc_q <= tick ? '0 : presc_q + 1'b1;
            // a phase change restarts timing even while held, so it is never missed
            if (phase_in != phase_q) begin
                state_q    <= S_MIN;
                pt_q       <= '0;
                clearing_q <= 1'b0;
                gap_q      <= CNT_W'(GAP);
                clr_q      <= '0;
            end else if (tick) begin
                case (state_q)
                    S_MIN: begin
                        pt_q <= pt_d;
                        if (pt_q == CNT_W'(GREEN_MIN - 1)) begin
                            state_q <= S_EXT;
                            gap_q   <= CNT_W'(GAP);
                        end
                    end
                    S_EXT: begin
                        pt_q <= pt_d;
                        if (pt_q == CNT_W'(GREEN_MAX - 1) || (!demand && gap_q == CNT_W'(1))) begin
                            state_q    <= S_CLR;
                            clearing_q <= 1'b1;
                            clr_q      <= '0;
                        end else begin
                            gap_q <= demand ? CNT_W'(GAP) : gap_q - 1'b1;
                        end
                    end
                    S_CLR: begin
                        if (clr_q == CNT_W'(CLEAR - 1)) begin
                            state_q    <= S_MIN;
                            advance_q  <= 1'b1;
                            clearing_q <= 1'b0;
                            pt_q       <= '0;
                        end else begin
                            clr_q <= clr_q + 1'b1;
                        end
                    end
                    default: state_q <= S_MIN;
                endcase
            end
        end
    end
    assign advance    = advance_q;
    assign clearing   = clearing_q;
    assign phase_time = pt_q;
    assign err        = err_q;
endmodule

// File: tb/tb_tlc_phase_timer.sv
// tb_tlc_phase_timer: directed edge-accurate checks of the phase timer with small parameters
module tb_tlc_phase_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] phase_in = 3'd0;
    logic [3:0] veh_det = 4'd0;
    logic       hold = 1'b0;
    logic       advance, clearing, err;
    logic [7:0] phase_time;
    int total = 0, bad = 0, e = 0;

    tlc_phase_timer #(.PRESCALE(4), .GREEN_MIN(3), .GREEN_MAX(6), .GAP(2), .CLEAR(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .phase_in(phase_in), .veh_det(veh_det), .hold(hold),
        .advance(advance), .clearing(clearing), .phase_time(phase_time), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, e, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_adv", advance, 0);
        chk("rst_clr", clearing, 0);
        chk("rst_pt", phase_time, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
    endtask

    task automatic to(input int k);
        while (e < k) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    initial begin
        // gap-out with no demand
        do_reset();
        to(19); chk("go_clr19", clearing, 0); chk("go_pt19", phase_time, 4);
        to(20); chk("go_clr20", clearing, 1); chk("go_pt20", phase_time, 5);
        to(23); chk("go_adv23", advance, 0);
        to(24); chk("go_adv24", advance, 1); chk("go_clr24", clearing, 0); chk("go_pt24", phase_time, 0);
        to(25); chk("go_adv25", advance, 0);
        // max-out with constant green demand
        veh_det = 4'b0101;
        do_reset();
        to(23); chk("mo_clr23", clearing, 0);
        to(24); chk("mo_clr24", clearing, 1); chk("mo_pt24", phase_time, 6); chk("mo_adv24", advance, 0);
        to(27); chk("mo_adv27", advance, 0); chk("mo_pt27", phase_time, 6);
        to(28); chk("mo_adv28", advance, 1);
        to(29); chk("mo_adv29", advance, 0);
        // demand only on a non-green approach
        phase_in = 3'd2; veh_det = 4'b0010;
        do_reset();
        to(23); chk("ng_adv23", advance, 0);
        to(24); chk("ng_adv24", advance, 1);
        // single green pulse on tick 4 reloads the gap
        veh_det = 4'b0000;
        do_reset();
        to(15); veh_det = 4'b0001;
        to(16); veh_det = 4'b0000;
        to(24); chk("rl_adv24", advance, 0); chk("rl_clr24", clearing, 1);
        to(28); chk("rl_adv28", advance, 1);
        // hold for 8 clks across the tick-6 window
        phase_in = 3'd0;
        do_reset();
        to(22); hold = 1'b1;
        to(24); chk("hd_adv24", advance, 0); chk("hd_clr24", clearing, 1);
        to(30); hold = 1'b0; chk("hd_adv30", advance, 0);
        to(31); chk("hd_adv31", advance, 0);
        to(32); chk("hd_adv32", advance, 1);
        to(33); chk("hd_adv33", advance, 0);
        // out-of-sequence jump mid-EXTEND
        veh_det = 4'b0101;
        do_reset();
        to(17); chk("jp_pt17", phase_time, 4); phase_in = 3'd3;
        to(18); chk("jp_pt18", phase_time, 0); chk("jp_clr18", clearing, 0);
        to(24); chk("jp_adv24", advance, 0); chk("jp_clr24", clearing, 0);
        to(36); chk("jp_clr36", clearing, 1);
        to(39); chk("jp_adv39", advance, 0);
        to(40); chk("jp_adv40", advance, 1);
        // illegal phase sets sticky err
        to(41); chk("er_pre", err, 0); phase_in = 3'd7;
        to(42); chk("er_set", err, 1); phase_in = 3'd0;
        to(50); chk("er_stk", err, 1);
        // async reset during clearance
        veh_det = 4'b0000;
        do_reset();
        to(21); chk("ar_clr21", clearing, 1);
        #2 rst = 1'b1;
        #1 chk("ar_clr", clearing, 0); chk("ar_adv", advance, 0); chk("ar_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
        to(23); chk("ar_adv23", advance, 0);
        to(24); chk("ar_adv24", advance, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
